// File: rtl/csr_req_gen_if.sv
// Bundle between writeback/CSR file (master side) and csr_req_gen (slave side).
// Latency: none, wires only.
// Backpressure: req_ready gates acceptance; CSR and redirect strobes are single-cycle, no stall.
interface csr_req_gen_if #(
    parameter int XLEN = 64
);
    // request from writeback
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [11:0]     req_csr;
    logic [XLEN-1:0] req_src;
    logic            req_src_zero;
    logic [XLEN-1:0] req_pc;
    logic            req_exc;
    logic            req_mret;
    logic            flush;

    // CSR file command/read port
    logic [11:0]     csr_ra;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_valid;
    logic            csr_w_valid;
    logic [11:0]     csr_wa;
    logic [XLEN-1:0] csr_wd;
    logic            csr_is_exc;
    logic            csr_is_mret;
    logic [XLEN-1:0] csr_pc;

    // rd writeback and fetch redirect
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    // environment side: writeback stage plus CSR file read data
    modport master (
        output req_valid, req_op, req_csr, req_src, req_src_zero, req_pc,
               req_exc, req_mret, flush, csr_rdata,
        input  req_ready, csr_ra, csr_valid, csr_w_valid, csr_wa, csr_wd,
               csr_is_exc, csr_is_mret, csr_pc, resp_valid, resp_rdata,
               redirect_valid, redirect_pc
    );

    // request generator side
    modport slave (
        input  req_valid, req_op, req_csr, req_src, req_src_zero, req_pc,
               req_exc, req_mret, flush, csr_rdata,
        output req_ready, csr_ra, csr_valid, csr_w_valid, csr_wa, csr_wd,
               csr_is_exc, csr_is_mret, csr_pc, resp_valid, resp_rdata,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/csr_req_gen.sv
// Turns committed CSR ops / traps / mret into read-then-write CSR commands plus rd result and PC redirect.
// Latency: accept at edge T, read during T+1, command/resp/redirect during T+2, ready again in T+3.
// Backpressure: req_ready low while a sequence runs; outputs are one-cycle pulses with no downstream stall.
module csr_req_gen #(
    parameter int          XLEN       = 64,
    parameter logic [11:0] MTVEC_ADDR = 12'h305,
    parameter logic [11:0] MEPC_ADDR  = 12'h341
) (
    input  logic         clk,
    input  logic         reset,
    csr_req_gen_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        CSR_RD,
        CSR_WR,
        TRAP_RD,
        TRAP_WR,
        MRET_RD,
        MRET_WR
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [11:0]     csr_q, csr_d;
    logic [XLEN-1:0] src_q, src_d;
    logic            src_zero_q, src_zero_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] old_q, old_d;

    logic [XLEN-1:0] new_val;
    logic            wr_en;

    // Next state: latch the request in IDLE, capture read data in any *_RD state, flush only before commit
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        csr_d      = csr_q;
        src_d      = src_q;
        src_zero_d = src_zero_q;
        pc_d       = pc_q;
        old_d      = old_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    op_d       = bus.req_op;
                    csr_d      = bus.req_csr;
                    src_d      = bus.req_src;
                    src_zero_d = bus.req_src_zero;
                    pc_d       = bus.req_pc;
                    // trap beats mret beats a plain CSR op
                    if (bus.req_exc) begin
                        state_d = TRAP_RD;
                    end else if (bus.req_mret) begin
                        state_d = MRET_RD;
                    end else begin
                        state_d = CSR_RD;
                    end
                end
            end
            CSR_RD: begin
                old_d   = bus.csr_rdata;
                state_d = bus.flush ? IDLE : CSR_WR;
            end
            TRAP_RD: begin
                old_d   = bus.csr_rdata;
                state_d = bus.flush ? IDLE : TRAP_WR;
            end
            MRET_RD: begin
                old_d   = bus.csr_rdata;
                state_d = bus.flush ? IDLE : MRET_WR;
            end
            // write cycles are the commit point: always complete
            CSR_WR, TRAP_WR, MRET_WR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request latches; reset abandons any sequence in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= 3'b000;
            csr_q      <= 12'h000;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            pc_q       <= '0;
            old_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            csr_q      <= csr_d;
            src_q      <= src_d;
            src_zero_q <= src_zero_d;
            pc_q       <= pc_d;
            old_q      <= old_d;
        end
    end

    // New CSR value and write enable; set/clear with a zero operand and read-only CSRs never write
    always_comb begin
        new_val = src_q;
        case (op_q)
            3'b001, 3'b101: new_val = src_q;
            3'b010, 3'b110: new_val = old_q | src_q;
            3'b011, 3'b111: new_val = old_q & ~src_q;
            default:        new_val = src_q;
        endcase
        // op_q[1] marks the set/clear family
        wr_en = !((op_q[1] && src_zero_q) || (csr_q[11:10] == 2'b11));
    end

    // Moore outputs: buses are zero outside the state that owns them
    always_comb begin
        bus.req_ready      = 1'b0;
        bus.csr_ra         = 12'h000;
        bus.csr_valid      = 1'b0;
        bus.csr_w_valid    = 1'b0;
        bus.csr_wa         = 12'h000;
        bus.csr_wd         = '0;
        bus.csr_is_exc     = 1'b0;
        bus.csr_is_mret    = 1'b0;
        bus.csr_pc         = '0;
        bus.resp_valid     = 1'b0;
        bus.resp_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        case (state_q)
            IDLE:    bus.req_ready = 1'b1;
            CSR_RD:  bus.csr_ra    = csr_q;
            TRAP_RD: bus.csr_ra    = MTVEC_ADDR;
            MRET_RD: bus.csr_ra    = MEPC_ADDR;
            CSR_WR: begin
                bus.csr_valid   = 1'b1;
                bus.csr_w_valid = wr_en;
                bus.csr_wa      = csr_q;
                bus.csr_wd      = new_val;
                bus.resp_valid  = 1'b1;
                bus.resp_rdata  = old_q;
            end
            TRAP_WR: begin
                bus.csr_valid      = 1'b1;
                bus.csr_is_exc     = 1'b1;
                bus.csr_pc         = pc_q;
                bus.redirect_valid = 1'b1;
                // direct mode only: mtvec mode bits dropped
                bus.redirect_pc    = {old_q[XLEN-1:2], 2'b00};
            end
            MRET_WR: begin
                bus.csr_valid      = 1'b1;
                bus.csr_is_mret    = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = old_q;
            end
            default: bus.req_ready = 1'b0;
        endcase
    end

endmodule
